// File: rtl/dmac_pkg.sv
// Shared helpers for the mchan control-port multiplexer.
// Index width keeps a 1-bit field for the single-port case so structs never collapse to zero width.
package dmac_pkg;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmac_outstnd_fifo.sv
// In-order outstanding-request FIFO: push/pop in one cycle, head visible combinationally (read-first).
// No backpressure of its own; callers must gate push on full and pop on empty.
module dmac_outstnd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra wrap bit on each pointer tells full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/dmac_ctrl_mux.sv
// N-to-1 control mux in front of mchan: combinational RR/fixed arbitration, 0-cycle grant and response routing.
// Backpressure: no grants while the outstanding FIFO is full; responses are routed back in grant order.
module dmac_ctrl_mux
    import dmac_pkg::*;
#(
    parameter int NB_CTRLS      = 10,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int PE_ID_WIDTH   = 1,
    parameter int OUTSTND_DEPTH = 4,
    parameter int RR_MODE       = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NB_CTRLS-1:0]                ctrl_req_i,
    input  logic [NB_CTRLS*ADDR_WIDTH-1:0]     ctrl_add_i,
    input  logic [NB_CTRLS-1:0]                ctrl_wen_i,
    input  logic [NB_CTRLS*(DATA_WIDTH/8)-1:0] ctrl_be_i,
    input  logic [NB_CTRLS*DATA_WIDTH-1:0]     ctrl_wdata_i,
    input  logic [NB_CTRLS*PE_ID_WIDTH-1:0]    ctrl_id_i,
    output logic [NB_CTRLS-1:0]                ctrl_gnt_o,
    output logic [NB_CTRLS-1:0]                ctrl_r_valid_o,
    output logic [DATA_WIDTH-1:0]              ctrl_r_rdata_o,
    output logic                               ctrl_r_opc_o,
    output logic [PE_ID_WIDTH-1:0]             ctrl_r_id_o,
    output logic                               tgt_req_o,
    output logic [ADDR_WIDTH-1:0]              tgt_add_o,
    output logic                               tgt_wen_o,
    output logic [DATA_WIDTH/8-1:0]            tgt_be_o,
    output logic [DATA_WIDTH-1:0]              tgt_wdata_o,
    output logic [PE_ID_WIDTH-1:0]             tgt_id_o,
    input  logic                               tgt_gnt_i,
    input  logic                               tgt_r_valid_i,
    input  logic [DATA_WIDTH-1:0]              tgt_r_rdata_i,
    input  logic                               tgt_r_opc_i,
    output logic                               busy_o,
    output logic                               err_o
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = idx_w(NB_CTRLS);

    typedef struct packed {
        logic [IDX_W-1:0]       idx;
        logic [PE_ID_WIDTH-1:0] pe_id;
    } ctrl_outstnd_t;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] win_lo;
    logic [IDX_W-1:0] win_hi;
    logic [IDX_W-1:0] winner;
    logic             hi_vld;
    logic             fifo_full;
    logic             fifo_empty;
    logic             handshake;
    logic             pop;
    logic             err_q;
    ctrl_outstnd_t    push_ent;
    ctrl_outstnd_t    head_ent;

    // Two lowest-index searches: over ports at/after the pointer, and over all ports for the wrap.
    always_comb begin
        win_lo = '0;
        win_hi = '0;
        hi_vld = 1'b0;
        for (int i = NB_CTRLS - 1; i >= 0; i--) begin
            if (ctrl_req_i[i]) begin
                win_lo = IDX_W'(i);
                if (IDX_W'(i) >= rr_ptr) begin
                    win_hi = IDX_W'(i);
                    hi_vld = 1'b1;
                end
            end
        end
        winner = (RR_MODE != 0 && hi_vld) ? win_hi : win_lo;
    end

    assign ptr_nxt   = (winner == IDX_W'(NB_CTRLS - 1)) ? '0 : winner + 1'b1;
    assign tgt_req_o = (|ctrl_req_i) && !fifo_full;
    assign handshake = tgt_req_o && tgt_gnt_i;
    assign pop       = tgt_r_valid_i && !fifo_empty;

    always_comb begin
        tgt_add_o   = '0;
        tgt_wen_o   = 1'b0;
        tgt_be_o    = '0;
        tgt_wdata_o = '0;
        tgt_id_o    = '0;
        ctrl_gnt_o  = '0;
        for (int i = 0; i < NB_CTRLS; i++) begin
            if (tgt_req_o && winner == IDX_W'(i)) begin
                tgt_add_o     = ctrl_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                tgt_wen_o     = ctrl_wen_i[i];
                tgt_be_o      = ctrl_be_i[i*BE_WIDTH +: BE_WIDTH];
                tgt_wdata_o   = ctrl_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                tgt_id_o      = ctrl_id_i[i*PE_ID_WIDTH +: PE_ID_WIDTH];
                ctrl_gnt_o[i] = tgt_gnt_i;
            end
        end
    end

    assign push_ent = '{idx: winner, pe_id: tgt_id_o};

    dmac_outstnd_fifo #(
        .WIDTH ($bits(ctrl_outstnd_t)),
        .DEPTH (OUTSTND_DEPTH)
    ) u_outstnd_fifo (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .push     (handshake),
        .push_dat (push_ent),
        .pop      (pop),
        .head     (head_ent),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        ctrl_r_valid_o = '0;
        for (int i = 0; i < NB_CTRLS; i++) begin
            if (pop && head_ent.idx == IDX_W'(i))
                ctrl_r_valid_o[i] = 1'b1;
        end
        ctrl_r_id_o    = pop ? head_ent.pe_id : '0;
        ctrl_r_rdata_o = pop ? tgt_r_rdata_i : '0;
        ctrl_r_opc_o   = pop && tgt_r_opc_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
            err_q  <= 1'b0;
        end else begin
            if (handshake && RR_MODE != 0)
                rr_ptr <= ptr_nxt;
            // A response with nothing outstanding is dropped but remembered.
            if (tgt_r_valid_i && fifo_empty)
                err_q <= 1'b1;
        end
    end

    assign busy_o = !fifo_empty;
    assign err_o  = err_q;

endmodule
